// File: rtl/srl_sra_seq.sv
// srl_sra_seq: multi-cycle right shifter, one bit per clock.
// Logical (zero fill) or arithmetic (sign fill). Uses a START/DONE handshake
// so the ALU control FSM can run SRL/SRA/SRLV/SRAV without a barrel shifter.
module srl_sra_seq #(
    parameter int N = 32,
    parameter int M = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [M-1:0] SHIFT_AMT,
    input  logic         ARITH,
    output logic [N-1:0] Y,
    output logic         BUSY,
    output logic         READY,
    output logic         DONE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    state_t       state_q;
    logic [N-1:0] y_q;
    logic [M-1:0] cnt_q;
    logic         fill_q;
    logic         busy_q;
    logic         ready_q;
    logic         done_q;

    logic [N-1:0] y_shr_d;
    logic [M-1:0] cnt_dec_d;

    // One-position shift step using the fill bit latched at accept time
    always_comb begin
        y_shr_d   = {fill_q, y_q[N-1:1]};
        cnt_dec_d = cnt_q - M'(1);
    end

    // Control FSM with registered handshake outputs; a START is only taken
    // from IDLE or FIN, so requests arriving while shifting are dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_FIN: begin
                    if (START) begin
                        y_q    <= A;
                        cnt_q  <= SHIFT_AMT;
                        fill_q <= ARITH & A[N-1];
                        if (SHIFT_AMT != '0) begin
                            state_q <= S_SHIFT;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b0;
                            done_q  <= 1'b0;
                        end else begin
                            // Zero count: result is A, report it next cycle
                            state_q <= S_FIN;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    y_q   <= y_shr_d;
                    cnt_q <= cnt_dec_d;
                    if (cnt_q == M'(1)) begin
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Y     = y_q;
    assign BUSY  = busy_q;
    assign READY = ready_q;
    assign DONE  = done_q;

endmodule

// File: doc/srl_sra_seq.md
Name: srl_sra_seq

Overview:
- Multi-cycle right shifter; the right-shift counterpart of the team's combinational logical-shift-left unit.
- Shifts one bit position per clock. Supports logical (zero fill) and arithmetic (sign fill) modes.
- Uses a START/DONE handshake so the ALU32 control FSM can use it for SRL/SRA/SRLV/SRAV without a full barrel shifter on the critical path.

Parameters:
- N, 32, operand/result width in bits
- M, 5, shift-amount width in bits (2^M >= N)

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous reset, active-high
- START  input  1  request; sampled only when READY=1
- A  input  N  operand, captured on accepted START
- SHIFT_AMT  input  M  shift count, unsigned, captured on accepted START
- ARITH  input  1  1 = arithmetic (replicate A[N-1]), 0 = logical (zero fill); captured on accepted START
- Y  output  N  result register
- BUSY  output  1  high while shifting
- READY  output  1  high when a START will be accepted
- DONE  output  1  one-cycle pulse: Y is the valid final result

Behaviour:
- Clock and reset:
  - One clock, CLK. Reset RST is synchronous and active-high.
  - While RST=1 at a rising edge: state=IDLE, Y=0, counter=0, fill bit=0, BUSY=0, DONE=0, READY=1.
- States:
  - IDLE: READY=1, BUSY=0, DONE=0.
  - SHIFT: READY=0, BUSY=1, DONE=0.
  - FIN: READY=1, BUSY=0, DONE=1.
- Accept:
  - START=1 in IDLE or FIN at an edge loads Y<=A and cnt<=SHIFT_AMT.
  - The same edge latches fill <= ARITH & A[N-1].
  - Next state: SHIFT if SHIFT_AMT!=0, else FIN.
- SHIFT step: each edge sets Y <= {fill, Y[N-1:1]} and cnt <= cnt-1. When cnt==1 at that edge, next state is FIN.
- FIN:
  - Lasts exactly one cycle.
  - Next state is IDLE, unless START=1, in which case it is accepted back-to-back per the Accept rule.
- Latency:
  - DONE is high in the cycle that begins SHIFT_AMT+1 edges after the accepting edge.
  - SHIFT_AMT=0 gives DONE on the very next cycle with Y=A.
- Y holding:
  - Y holds its value after FIN until the next accepted START.
  - Y shows intermediate values during SHIFT; consumers must use DONE.
- START ignored cases:
  - START while BUSY=1 is ignored. No effect on Y, cnt, or latched mode.
  - The host does not queue requests.
- Input capture: A, SHIFT_AMT and ARITH are don't-care except at the accepting edge. Later changes do not affect the in-flight operation.
- Width rule:
  - SHIFT_AMT >= N is not clamped.
  - Shifting continues for SHIFT_AMT cycles, giving all fill bits (0 or all-ones).
- Arithmetic with A[N-1]=0 gives the same result as logical.
- Reset mid-operation: RST in SHIFT aborts the operation. The next cycle is IDLE with Y=0, and no DONE pulse is issued.
- RST and START together: RST wins.

Test Plan:
- Logical shift: RST 2 cycles, then START with A=0x80000000, SHIFT_AMT=4, ARITH=0 -> BUSY high 4 cycles; DONE pulses 5 cycles after accept; Y=0x08000000; READY back to 1.
- Arithmetic shift: A=0x80000000, SHIFT_AMT=4, ARITH=1 -> Y=0xF8000000 at DONE. Repeat with A=0x7FFFFFF0 -> Y=0x07FFFFFF.
- Zero and maximum counts:
  - SHIFT_AMT=0, A=0xDEADBEEF -> DONE next cycle, Y=0xDEADBEEF, BUSY never high.
  - SHIFT_AMT=31, ARITH=1, A=0x80000001 -> Y=0xFFFFFFFF after 32 cycles.
  - SHIFT_AMT=31, ARITH=0 -> Y=0x00000001.
- Ignored start: START with A=0xFFFF0000, SHIFT_AMT=8, ARITH=0; re-assert START with A=0x12345678 at cycle 3 -> ignored; Y=0x00FFFF00 at DONE (cycle 9).
- Back-to-back: during the DONE cycle, START with A=0x00000100, SHIFT_AMT=8 -> accepted with no IDLE gap; next DONE 9 cycles later with Y=0x00000001.
- Reset mid-op: START with SHIFT_AMT=20, then RST at cycle 6 -> Y=0, BUSY=0, READY=1 next cycle; no DONE pulse within the following 20 cycles.
